// File: rtl/ps2_scancode_rx_if.sv
// Key-event bus between the PS/2 receiver and the keyboard matrix stage.
// Carries the raw PS/2 lines and the receive enable into the receiver, and the
// decoded key event back out.
//   master : receiver side (takes raw lines and enable, drives the event outputs)
//   slave  : consumer side (drives raw lines and enable, observes the events)
interface ps2_scancode_rx_if;
  logic       enable_rcv;
  logic       ps2clk_ext;
  logic       ps2data_ext;
  logic       kb_interrupt;
  logic [7:0] scancode;
  logic       released;
  logic       extended;
  logic       frame_err;

  modport master (
    input  enable_rcv, ps2clk_ext, ps2data_ext,
    output kb_interrupt, scancode, released, extended, frame_err
  );

  modport slave (
    output enable_rcv, ps2clk_ext, ps2data_ext,
    input  kb_interrupt, scancode, released, extended, frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver front-end. Synchronises and deglitches the raw PS/2
// clock/data lines, deserialises 11-bit device-to-host frames, checks parity and
// framing, folds E0/F0 prefixes into flags and emits one-cycle key events.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : ps2_scancode_rx_if.master (enable_rcv, ps2clk_ext, ps2data_ext in;
//              kb_interrupt, scancode, released, extended, frame_err out)
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input logic               clk,
  input logic               rst,
  ps2_scancode_rx_if.master bus
);

  localparam int unsigned FltW = $clog2(FILTER_LEN);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FltW-1:0] FltMax = FltW'(FILTER_LEN - 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Index 0 = PS/2 clock, index 1 = PS/2 data.
  logic [1:0]      sync1_q, sync2_q, filt_q;
  logic [FltW-1:0] flt_cnt_q [2];
  logic            filt_clk_prev_q;
  logic            fall, din;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            pend_ext_q, pend_ext_d;
  logic            pend_rel_q, pend_rel_d;
  logic            kb_q, kb_d;
  logic            err_q, err_d;
  logic [7:0]      code_q, code_d;
  logic            rel_q, rel_d;
  logic            ext_q, ext_d;

  // Synchroniser and glitch filter: the filtered level follows only after
  // FILTER_LEN consecutive samples that disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q         <= 2'b11;
      sync2_q         <= 2'b11;
      filt_q          <= 2'b11;
      filt_clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
    end else begin
      sync1_q         <= {bus.ps2data_ext, bus.ps2clk_ext};
      sync2_q         <= sync1_q;
      filt_clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (flt_cnt_q[i] == FltMax) begin
            filt_q[i]    <= sync2_q[i];
            flt_cnt_q[i] <= '0;
          end else begin
            flt_cnt_q[i] <= flt_cnt_q[i] + FltW'(1);
          end
        end else begin
          flt_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign fall = filt_clk_prev_q & ~filt_q[0];
  assign din  = filt_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      pend_ext_q <= 1'b0;
      pend_rel_q <= 1'b0;
      kb_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      rel_q      <= 1'b0;
      ext_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      pend_ext_q <= pend_ext_d;
      pend_rel_q <= pend_rel_d;
      kb_q       <= kb_d;
      err_q      <= err_d;
      code_q     <= code_d;
      rel_q      <= rel_d;
      ext_q      <= ext_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = '0;
    pend_ext_d = pend_ext_q;
    pend_rel_d = pend_rel_q;
    kb_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    rel_d      = rel_q;
    ext_d      = ext_q;

    if (!bus.enable_rcv) begin
      state_d    = StIdle;
      pend_ext_d = 1'b0;
      pend_rel_d = 1'b0;
    end else begin
      if (state_q != StIdle && !fall) tmo_d = tmo_q + TmoW'(1);

      unique case (state_q)
        StIdle: begin
          if (fall && !din) begin
            bit_cnt_d = '0;
            state_d   = StData;
          end
        end
        StData: begin
          if (fall) begin
            shift_d   = {din, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = StParity;
          end
        end
        StParity: begin
          if (fall) begin
            parity_d = din;
            state_d  = StStop;
          end
        end
        StStop: begin
          if (fall) begin
            state_d = StIdle;
            if (din && ^{shift_q, parity_q}) begin
              if (shift_q == 8'hE0) begin
                pend_ext_d = 1'b1;
              end else if (shift_q == 8'hF0) begin
                pend_rel_d = 1'b1;
              end else if (shift_q != 8'hE1) begin
                code_d     = shift_q;
                rel_d      = pend_rel_q;
                ext_d      = pend_ext_q;
                kb_d       = 1'b1;
                pend_ext_d = 1'b0;
                pend_rel_d = 1'b0;
              end
            end else begin
              err_d      = 1'b1;
              pend_ext_d = 1'b0;
              pend_rel_d = 1'b0;
            end
          end
        end
      endcase

      // A fall in the expiry cycle wins: the bit is taken and the counter clears.
      if (state_q != StIdle && !fall && tmo_q == TmoMax) begin
        state_d    = StIdle;
        tmo_d      = '0;
        err_d      = 1'b1;
        pend_ext_d = 1'b0;
        pend_rel_d = 1'b0;
      end
    end
  end

  assign bus.kb_interrupt = kb_q;
  assign bus.frame_err    = err_q;
  assign bus.scancode     = code_q;
  assign bus.released     = rel_q;
  assign bus.extended     = ext_q;

endmodule
